// File: rtl/register_file.sv
// Architectural register file for the mincore write-back stage.
// Two registered read ports with write-first bypass, one write port,
// register 0 hardwired to zero, and a pending-load scoreboard that
// drives a combinational stall toward decode.
//
// Stall semantics: stall is a "not ready" indication for the read
// request presented by decode (ren/raddr1/raddr2). While stall=1 the
// consumer holds ren and both addresses. The read is still performed,
// and the consumer discards that result. A request is accepted on the
// first rising edge where ren=1 and stall=0.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ren,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              load_issue,
    input  logic [ADDR_W-1:0] load_rd,
    output logic              stall
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;
    logic              wr_live;
    logic              hit1;
    logic              hit2;

    // A write-back only lands when it targets a real register.
    assign wr_live = we && (waddr != '0);

    // Value a read port captures: zero for r0, the in-flight write for a
    // matching address, otherwise the stored contents.
    function automatic logic [DATA_W-1:0] read_value(
        input logic [ADDR_W-1:0] addr,
        input logic              wr_live_i,
        input logic [ADDR_W-1:0] waddr_i,
        input logic [DATA_W-1:0] wdata_i,
        input logic [DATA_W-1:0] stored
    );
        if (addr == '0) begin
            return '0;
        end else if (wr_live_i && (waddr_i == addr)) begin
            return wdata_i;
        end else begin
            return stored;
        end
    endfunction

    // Register array: write-back port, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[waddr] <= wdata;
        end
    end

    // Read ports: registered, hold their value while ren is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else if (ren) begin
            rdata1 <= read_value(raddr1, wr_live, waddr, wdata, mem[raddr1]);
            rdata2 <= read_value(raddr2, wr_live, waddr, wdata, mem[raddr2]);
        end
    end

    // Scoreboard next state: write-back clears, a new load sets; the set
    // is applied last so a newly issued load supersedes a same-address
    // write-back. Entry 0 can never be pending.
    always_comb begin
        busy_next = busy;
        if (we) begin
            busy_next[waddr] = 1'b0;
        end
        if (load_issue && (load_rd != '0)) begin
            busy_next[load_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Hazard detect: a pending source stalls unless its write-back arrives
    // this cycle, in which case the bypass supplies the data.
    always_comb begin
        hit1  = busy[raddr1] && !(we && (waddr == raddr1));
        hit2  = busy[raddr2] && !(we && (waddr == raddr2));
        stall = ren && (hit1 || hit2);
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: read results are checked through an
// expected-value queue popped by a monitor; stall and reset values are
// checked directly by the driver.
module tb_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          ren;
    logic [AW-1:0] raddr1;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata1;
    logic [DW-1:0] rdata2;
    logic          load_issue;
    logic [AW-1:0] load_rd;
    logic          stall;

    logic [2*DW-1:0] exp_q[$];
    logic            expect_rd;
    int              checks;
    int              errors;

    register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .load_issue(load_issue), .load_rd(load_rd), .stall(stall)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*DW-1:0] act,
                         input logic [2*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        we = 0; waddr = 0; wdata = 0; ren = 0; raddr1 = 0; raddr2 = 0;
        load_issue = 0; load_rd = 0; expect_rd = 0;
    endtask

    // One cycle of stimulus: drive at the falling edge, check stall just
    // after, queue the expected read result, then let the rising edge pass.
    task automatic cyc(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic r, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic li, input logic [AW-1:0] lr,
                       input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                       input logic e_stall);
        @(negedge clk);
        we = w; waddr = wa; wdata = wd; ren = r; raddr1 = a1; raddr2 = a2;
        load_issue = li; load_rd = lr;
        expect_rd = r;
        if (r) exp_q.push_back({e1, e2});
        #1;
        check("stall", {63'd0, stall}, {63'd0, e_stall});
        @(posedge clk);
    endtask

    // Monitor: a read issued before this edge presents data after it.
    initial begin
        logic            fire;
        logic [2*DW-1:0] e;
        forever begin
            @(posedge clk);
            fire = expect_rd;
            #1;
            if (fire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rdata_unexpected: got %h expected none", {rdata1, rdata2});
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", {rdata1, rdata2}, e);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        idle();
        rst = 1'b1;
        #12;
        check("reset_rdata", {rdata1, rdata2}, 64'd0);
        check("reset_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Mid-operation reset: r5 written and read via bypass, load to r6 pending
        cyc(1, 5, 32'h12345678, 1, 5, 5, 0, 0, 32'h12345678, 32'h12345678, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0);
        @(negedge clk);
        idle();
        #2 rst = 1'b1;
        #1;
        check("async_reset_rdata", {rdata1, rdata2}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc(0, 0, 0, 1, 5, 6, 0, 0, 32'h0, 32'h0, 0);

        // Basic write then read, r0 on port 2
        cyc(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 3, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0);
        // Write to r0 is discarded, including through the bypass
        cyc(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0);
        cyc(0, 0, 0, 1, 0, 3, 0, 0, 32'h0, 32'hDEADBEEF, 0);

        // Bypass on both ports, then hold with ren=0
        cyc(1, 7, 32'hA5A5A5A5, 1, 7, 7, 0, 0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0);
        cyc(1, 7, 32'h11111111, 0, 7, 7, 0, 0, 0, 0, 0);
        #1;
        check("hold_rdata", {rdata1, rdata2}, {32'hA5A5A5A5, 32'hA5A5A5A5});
        cyc(0, 0, 0, 1, 7, 7, 0, 0, 32'h11111111, 32'h11111111, 0);

        // Load-use stall on port 2 until write-back resolves it
        cyc(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0, 9, 0, 0, 32'h0, 32'h0, 1);
        end
        cyc(1, 9, 32'h55, 1, 0, 9, 0, 0, 32'h0, 32'h55, 0);
        cyc(0, 0, 0, 1, 0, 9, 0, 0, 32'h0, 32'h55, 0);

        // Load issued with a same-cycle read: stall only from next cycle (port 1)
        cyc(0, 0, 0, 1, 10, 0, 1, 10, 32'h0, 32'h0, 0);
        cyc(0, 0, 0, 1, 10, 0, 0, 0, 32'h0, 32'h0, 1);
        cyc(1, 10, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 10, 0, 0, 0, 32'h77, 32'h0, 0);

        // Set/clear collision on r4: set wins
        cyc(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0);
        cyc(1, 4, 32'h44, 0, 0, 0, 1, 4, 0, 0, 0);
        cyc(0, 0, 0, 1, 4, 0, 0, 0, 32'h44, 32'h0, 1);
        cyc(1, 4, 32'h45, 1, 4, 0, 0, 0, 32'h45, 32'h0, 0);

        // Load to r0 never marks r0 pending
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0);

        @(negedge clk);
        idle();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
